// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: access FSM states and grant owners.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Access FSM: wait for a request, run the fixed-latency access, then pulse ready.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_e;

    // Owner of the access in flight.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access; data wins.
// Latency: request in IDLE cycle t -> BUSY t+1..t+MEM_LATENCY -> ready pulse t+MEM_LATENCY+1.
// Backpressure: stall_if_o / stall_mem_o hold the pipeline until the owner's ready pulse.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // instruction fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    // data port
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    // backing memory
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // pipeline stalls
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    localparam int                CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic dm_req;
    assign dm_req = dm_read_i | dm_write_i;

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_I;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Next-state: grant with data priority, count down the access, capture read data.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (dm_req) begin
                    // read+write together is illegal; the write wins
                    gnt_d   = GNT_D;
                    addr_d  = dm_addr_i;
                    wdata_d = dm_wdata_i;
                    we_d    = dm_write_i;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end else if (if_req_i) begin
                    gnt_d   = GNT_I;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // only the owner's read register moves; writes leave both alone
                    if (!we_q) begin
                        if (gnt_q == GNT_D) begin
                            dm_rdata_d = mem_rdata_i;
                        end else begin
                            if_rdata_d = mem_rdata_i;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // requests are ignored here so the requester can advance at this edge
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic done_pulse;
    // A reset arriving in DONE suppresses the pulse rather than letting it leak out.
    assign done_pulse  = (state_q == DONE) && !rst_i;

    assign if_ready_o  = done_pulse && (gnt_q == GNT_I);
    assign dm_ready_o  = done_pulse && (gnt_q == GNT_D);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

    assign mem_en_o    = (state_q == BUSY);
    assign mem_we_o    = (state_q == BUSY) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Stalls fall in the ready cycle so the pipeline advances on that same edge.
    assign stall_if_o  = if_req_i & ~if_ready_o;
    assign stall_mem_o = dm_req & ~dm_ready_o;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: three arbiter instances (latency 2 with a word memory, latency 1 and 5).
// Latency: n/a.
// Backpressure: requests held until ready, dropped in the cycle after the pulse.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_mem = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // one cycle: land 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- main instance, MEM_LATENCY=2 ----------------
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_read = 1'b0, dm_write = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        stall_if, stall_mem;

    unified_mem_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .dm_read_i(dm_read), .dm_write_i(dm_write), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
        .mem_en_o(m_en), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
        .mem_rdata_i(m_rdata),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem)
    );

    // word memory: word i initialised to 0xA5A5_0000 | i
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (m_en && m_we) begin
            mem[m_addr[9:2]] <= m_wdata;
        end
    end
    assign m_rdata = mem[m_addr[9:2]];

    // ---------------- latency 1 and 5 instances (fetch port only) ----------------
    logic        l1_req = 1'b0, l5_req = 1'b0;
    logic [31:0] l1_addr = '0, l5_addr = '0;
    logic [31:0] l1_if_rdata, l1_dm_rdata, l1_m_addr, l1_m_wdata;
    logic        l1_if_ready, l1_dm_ready, l1_m_en, l1_m_we, l1_stall_if, l1_stall_mem;
    logic [31:0] l5_if_rdata, l5_dm_rdata, l5_m_addr, l5_m_wdata;
    logic        l5_if_ready, l5_dm_ready, l5_m_en, l5_m_we, l5_stall_if, l5_stall_mem;

    unified_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(l1_req), .if_addr_i(l1_addr), .if_rdata_o(l1_if_rdata), .if_ready_o(l1_if_ready),
        .dm_read_i(1'b0), .dm_write_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
        .dm_rdata_o(l1_dm_rdata), .dm_ready_o(l1_dm_ready),
        .mem_en_o(l1_m_en), .mem_we_o(l1_m_we), .mem_addr_o(l1_m_addr), .mem_wdata_o(l1_m_wdata),
        .mem_rdata_i(~l1_m_addr),
        .stall_if_o(l1_stall_if), .stall_mem_o(l1_stall_mem)
    );

    unified_mem_arbiter #(.MEM_LATENCY(5), .ADDR_W(32), .DATA_W(32)) u_dut_l5 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(l5_req), .if_addr_i(l5_addr), .if_rdata_o(l5_if_rdata), .if_ready_o(l5_if_ready),
        .dm_read_i(1'b0), .dm_write_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
        .dm_rdata_o(l5_dm_rdata), .dm_ready_o(l5_dm_ready),
        .mem_en_o(l5_m_en), .mem_we_o(l5_m_we), .mem_addr_o(l5_m_addr), .mem_wdata_o(l5_m_wdata),
        .mem_rdata_i(~l5_m_addr),
        .stall_if_o(l5_stall_if), .stall_mem_o(l5_stall_mem)
    );

    initial begin
        // ---- reset ----
        rst = 1'b1;
        step();
        step();
        chk_eq("rst_state", 32'(u_dut.state_q), 32'(IDLE));
        chk_eq("rst_if_ready", 32'(if_ready), 32'd0);
        chk_eq("rst_dm_ready", 32'(dm_ready), 32'd0);
        chk_eq("rst_mem_en", 32'(m_en), 32'd0);
        chk_eq("rst_mem_we", 32'(m_we), 32'd0);
        chk_eq("rst_mem_addr", m_addr, 32'd0);
        chk_eq("rst_if_rdata", if_rdata, 32'd0);
        chk_eq("rst_dm_rdata", dm_rdata, 32'd0);
        rst = 1'b0;
        init_mem = 1'b0;
        step();

        // ---- single fetch of word 0 ----
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin if_req = 1'b1; if_addr = 32'h0; end
            if (c == 5) if_req = 1'b0;
            #1;
            chk_eq("f1_mem_en", 32'(m_en), 32'((c == 2) || (c == 3)));
            chk_eq("f1_if_ready", 32'(if_ready), 32'(c == 4));
            chk_eq("f1_stall_if", 32'(stall_if), 32'(c <= 3));
            if (c == 2) chk_eq("f1_mem_addr", m_addr, 32'h0);
            if (c == 4) chk_eq("f1_if_rdata", if_rdata, 32'hA5A5_0000);
            step();
        end

        // ---- fetch 0x8 and data read 0x40 together: data first ----
        for (int c = 1; c <= 9; c++) begin
            if (c == 1) begin
                if_req = 1'b1; if_addr = 32'h8;
                dm_read = 1'b1; dm_addr = 32'h40;
            end
            if (c == 5) dm_read = 1'b0;
            if (c == 9) if_req = 1'b0;
            #1;
            chk_eq("pri_dm_ready", 32'(dm_ready), 32'(c == 4));
            chk_eq("pri_if_ready", 32'(if_ready), 32'(c == 8));
            chk_eq("pri_stall_if", 32'(stall_if), 32'(c <= 7));
            chk_eq("pri_stall_mem", 32'(stall_mem), 32'(c <= 3));
            chk_eq("pri_mem_en", 32'(m_en), 32'(c == 2 || c == 3 || c == 6 || c == 7));
            if (c == 2) chk_eq("pri_addr_d", m_addr, 32'h40);
            if (c == 6) chk_eq("pri_addr_i", m_addr, 32'h8);
            if (c == 4) chk_eq("pri_dm_rdata", dm_rdata, 32'hA5A5_0010);
            if (c == 8) chk_eq("pri_if_rdata", if_rdata, 32'hA5A5_0002);
            step();
        end

        // ---- write 0xDEADBEEF to 0x10 ----
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin dm_write = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF; end
            if (c == 5) dm_write = 1'b0;
            #1;
            chk_eq("wr_mem_we", 32'(m_we), 32'((c == 2) || (c == 3)));
            chk_eq("wr_dm_ready", 32'(dm_ready), 32'(c == 4));
            if (c == 2) chk_eq("wr_mem_wdata", m_wdata, 32'hDEAD_BEEF);
            if (c == 4) chk_eq("wr_dm_rdata_kept", dm_rdata, 32'hA5A5_0010);
            step();
        end

        // ---- read back 0x10 ----
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin dm_read = 1'b1; dm_addr = 32'h10; end
            if (c == 5) dm_read = 1'b0;
            #1;
            chk_eq("rb_mem_we", 32'(m_we), 32'd0);
            chk_eq("rb_dm_ready", 32'(dm_ready), 32'(c == 4));
            if (c == 4) chk_eq("rb_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
            if (c == 4) chk_eq("rb_if_rdata_kept", if_rdata, 32'hA5A5_0002);
            step();
        end

        // ---- read and write both high: write performed ----
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin
                dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h1234_5678;
            end
            if (c == 5) begin dm_read = 1'b0; dm_write = 1'b0; end
            #1;
            chk_eq("rw_mem_we", 32'(m_we), 32'((c == 2) || (c == 3)));
            chk_eq("rw_dm_ready", 32'(dm_ready), 32'(c == 4));
            if (c == 4) chk_eq("rw_dm_rdata_kept", dm_rdata, 32'hDEAD_BEEF);
            step();
        end
        chk_eq("rw_mem_word", mem[8], 32'h1234_5678);

        // ---- reset during second BUSY cycle of a fetch ----
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin if_req = 1'b1; if_addr = 32'h4; end
            if (c == 3) rst = 1'b1;
            if (c == 4) begin rst = 1'b0; if_req = 1'b0; end
            #1;
            chk_eq("rb_abort_mem_en", 32'(m_en), 32'((c == 2) || (c == 3)));
            chk_eq("rb_abort_if_ready", 32'(if_ready), 32'd0);
            if (c == 4) chk_eq("rb_abort_state", 32'(u_dut.state_q), 32'(IDLE));
            if (c == 4) chk_eq("rb_abort_if_rdata", if_rdata, 32'd0);
            step();
        end

        // ---- MEM_LATENCY=1: ready two cycles after the grant cycle ----
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) begin l1_req = 1'b1; l1_addr = 32'h100; end
            if (c == 4) l1_req = 1'b0;
            #1;
            chk_eq("l1_mem_en", 32'(l1_m_en), 32'(c == 2));
            chk_eq("l1_if_ready", 32'(l1_if_ready), 32'(c == 3));
            if (c == 3) chk_eq("l1_if_rdata", l1_if_rdata, 32'hFFFF_FEFF);
            step();
        end

        // ---- MEM_LATENCY=5, request dropped mid-BUSY: ready still issued ----
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) begin l5_req = 1'b1; l5_addr = 32'h200; end
            if (c == 3) l5_req = 1'b0;
            #1;
            chk_eq("l5_mem_en", 32'(l5_m_en), 32'((c >= 2) && (c <= 6)));
            chk_eq("l5_if_ready", 32'(l5_if_ready), 32'(c == 7));
            chk_eq("l5_stall_if", 32'(l5_stall_if), 32'(c <= 2));
            if (c == 4) chk_eq("l5_mem_addr", l5_m_addr, 32'h200);
            if (c == 7) chk_eq("l5_if_rdata", l5_if_rdata, 32'hFFFF_FDFF);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified memory between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage pipeline. It serialises requests through a fixed-latency access FSM, gives data accesses strict priority, returns read data with a one-cycle ready pulse, and drives the stall signals that freeze the pipeline while an access is outstanding.

## Interface
- MEM_LATENCY, 2, backing-memory access time in cycles; legal range ≥1.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- if_req_i  in  1  fetch request, level; held until if_ready_o.
- if_addr_i  in  ADDR_W  fetch address (PC).
- if_rdata_o  out  DATA_W  fetched instruction; valid when if_ready_o=1.
- if_ready_o  out  1  one-cycle completion pulse for fetch.
- dm_read_i  in  1  data read request, level.
- dm_write_i  in  1  data write request, level.
- dm_addr_i  in  ADDR_W  data address (ALU result).
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  load data; valid when dm_ready_o=1.
- dm_ready_o  out  1  one-cycle completion pulse for data access.
- mem_en_o  out  1  memory enable; high for every BUSY cycle.
- mem_we_o  out  1  memory write enable; high for every BUSY cycle of a write.
- mem_addr_o  out  ADDR_W  latched access address.
- mem_wdata_o  out  DATA_W  latched store data.
- mem_rdata_i  in  DATA_W  memory read data; valid on the last BUSY cycle.
- stall_if_o  out  1  if_req_i & ~if_ready_o; freezes PC and IF/ID.
- stall_mem_o  out  1  (dm_read_i|dm_write_i) & ~dm_ready_o; freezes all pipeline registers.

## Operation
- FSM states: IDLE, BUSY, DONE. A grant register records the owner, I or D.
- IDLE: if dm_read_i|dm_write_i → grant D; else if if_req_i → grant I; else stay. On a grant, latch address, wdata, and we (dm_write_i for D, 0 for I), load counter = MEM_LATENCY-1, go to BUSY.
- BUSY: mem_en_o=1, mem_we_o=latched we. Decrement the counter each cycle. At counter=0, capture mem_rdata_i into the owner's rdata register (reads only) and go to DONE.
- DONE: pulse the owner's ready for exactly one cycle. Requests are not sampled in this cycle. Next state is IDLE.
- dm_read_i and dm_write_i both high is illegal. The write takes precedence.
- Writes leave dm_rdata_o unchanged. The non-owner's rdata register is never modified.
- Request inputs may change during BUSY. The latched address and data are used, and the ready pulse is still issued even if the request was dropped.
- Counter width is $clog2(MEM_LATENCY+1).

## Timing
- Reset: state=IDLE, counter=0, all outputs 0, including both rdata registers. Reset during BUSY or DONE aborts the access: no ready pulse and no further mem_en_o.
- Latency: a request first high in IDLE cycle t gives BUSY in cycles t+1..t+MEM_LATENCY and ready in cycle t+MEM_LATENCY+1, then IDLE at t+MEM_LATENCY+2.
- Throughput: at most one access per MEM_LATENCY+2 cycles.
- Simultaneous I and D requests in IDLE: D is served first. I waits with stall_if_o high and is granted in the IDLE cycle after D's DONE.
- Data priority is strict. Fetch cannot starve, because stall_mem_o freezes the pipeline and at most one data request is pending.
- Stall outputs are combinational from requests and ready. They drop in the same cycle as the ready pulse so the pipeline advances at that clock edge.
- Requesters deassert or advance their request at the edge that ends the ready cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - the state typedef: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - the grant constants: GNT_I=1'b0, GNT_D=1'b1.
- The block is a single module with no sub-modules; the latency counter is inline.
- The pipeline top replaces the separate Instruction_Memory and Data_Memory with this arbiter plus one memory. PC, IF/ID, ID/EX, EX/MEM and MEM/WB take the stall enables.

## Test plan (MEM_LATENCY=2 unless stated)
- Reset → all outputs 0 and state IDLE. if_req_i=1, if_addr_i=0x0 at cycle 1 → mem_en_o high in cycles 2–3, if_ready_o pulse in cycle 4 with if_rdata_o equal to memory word 0.
- if_req_i and dm_read_i both high in cycle 1, dm_addr_i=0x40 → D served first: dm_ready_o in cycle 4, if_ready_o in cycle 8, stall_if_o high in cycles 1–7.
- dm_write_i=1, addr 0x10, wdata 0xDEADBEEF → mem_we_o high in 2 cycles. A later read of 0x10 returns 0xDEADBEEF, and dm_rdata_o is unchanged after the write.
- dm_read_i and dm_write_i both high → write performed (mem_we_o=1).
- rst_i asserted in the second BUSY cycle → next cycle IDLE, no ready pulse, and mem_en_o=0.
- MEM_LATENCY=1 and 5: ready arrives exactly MEM_LATENCY+1 cycles after the IDLE grant cycle. Dropping the request mid-BUSY still produces the ready pulse.
